global_broadcast_unit: RTL and testbench

GLOBAL_BROADCAST_UNIT -- requirements
Module: global_broadcast_unit

---
 rtl/global_broadcast_unit_if.sv | 37 +++
 rtl/global_broadcast_unit.sv | 107 ++++++++++
 tb/tb_global_broadcast_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/global_broadcast_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : global_broadcast_unit_if
//  Description : Input value handshake and output pixel stream bundle for
//                the global broadcast unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface global_broadcast_unit_if #(
   parameter int IMG_W = 14,
   parameter int IMG_H = 14
);
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready;
   logic [COL_W-1:0] out_col;
   logic [ROW_W-1:0] out_row;
   logic             out_last;

   // Producer of values / consumer of pixels
   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_col, out_row, out_last
   );

   // The broadcast unit itself
   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_col, out_row, out_last
   );
endinterface
`default_nettype wire

// File: rtl/global_broadcast_unit.sv
`default_nettype none
// ============================================================================
//  Module      : global_broadcast_unit
//  Description : Expands each accepted 8-bit value into a full IMG_W x IMG_H
//                frame of identical pixels (inverse of global average
//                pooling). One-entry pending buffer allows frames to run
//                back-to-back without bubbles.
//  Revision    : 1.0 - initial release
// ============================================================================
module global_broadcast_unit #(
   parameter int IMG_W = 14,
   parameter int IMG_H = 14
) (
   input  wire logic             clk,
   input  wire logic             rst,
   global_broadcast_unit_if.slave bus
);
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   localparam logic [COL_W-1:0] c_COL_MAX = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] c_ROW_MAX = ROW_W'(IMG_H - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_EMIT = 1'b1;

   logic [0:0]       r_state;
   logic [7:0]       r_active;
   logic [7:0]       r_pend;
   logic             r_pend_valid;
   logic [COL_W-1:0] r_col;
   logic [ROW_W-1:0] r_row;

   logic w_emit;
   logic w_in_acc;
   logic w_out_xfer;
   logic w_col_end;
   logic w_last;

   // Handshake decode; in_ready depends only on registered state
   assign w_emit     = (r_state == S_EMIT);
   assign w_in_acc   = bus.in_valid && !r_pend_valid;
   assign w_out_xfer = w_emit && bus.out_ready;
   assign w_col_end  = (r_col == c_COL_MAX);
   assign w_last     = w_emit && w_col_end && (r_row == c_ROW_MAX);

   // Output drive: everything reads zero whenever no pixel is presented
   assign bus.in_ready  = !r_pend_valid;
   assign bus.out_valid = w_emit;
   assign bus.out_data  = w_emit ? r_active : 8'd0;
   assign bus.out_col   = w_emit ? r_col : '0;
   assign bus.out_row   = w_emit ? r_row : '0;
   assign bus.out_last  = w_last;

   // Frame sequencer: active value, pending buffer and pixel position
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_active     <= 8'd0;
         r_pend       <= 8'd0;
         r_pend_valid <= 1'b0;
         r_col        <= '0;
         r_row        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_in_acc) begin
                  r_active <= bus.in_data;
                  r_col    <= '0;
                  r_row    <= '0;
                  r_state  <= S_EMIT;
               end
            end
            default: begin
               if (w_out_xfer && w_last) begin
                  // Frame boundary: chain the next value with no gap if one exists
                  r_col <= '0;
                  r_row <= '0;
                  if (r_pend_valid) begin
                     r_active     <= r_pend;
                     r_pend_valid <= 1'b0;
                  end else if (w_in_acc) begin
                     r_active <= bus.in_data;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  if (w_out_xfer) begin
                     if (w_col_end) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                     end else begin
                        r_col <= r_col + 1'b1;
                     end
                  end
                  // Value arriving mid-frame waits in the pending buffer
                  if (w_in_acc) begin
                     r_pend       <= bus.in_data;
                     r_pend_valid <= 1'b1;
                  end
               end
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_global_broadcast_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_global_broadcast_unit
//  Description : Self-checking bench for global_broadcast_unit. A queue of
//                accepted values plus a pixel counter predicts the stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_global_broadcast_unit;
   localparam int IMG_W = 14;
   localparam int IMG_H = 14;
   localparam int NPIX  = IMG_W * IMG_H;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   // Reference model: values accepted but not yet fully emitted, head = active
   logic [7:0] q[$];
   int         pix_cnt;
   int         n_acc;

   global_broadcast_unit_if #(.IMG_W(IMG_W), .IMG_H(IMG_H)) bus ();

   global_broadcast_unit #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare every output against the model's view of the current cycle
   task automatic check_outputs();
      logic v;
      v = (q.size() > 0);
      check("out_valid", 32'(bus.out_valid), 32'(v));
      check("in_ready",  32'(bus.in_ready),  32'(q.size() <= 1));
      check("out_data",  32'(bus.out_data),  v ? 32'(q[0]) : 32'd0);
      check("out_col",   32'(bus.out_col),   v ? 32'(pix_cnt % IMG_W) : 32'd0);
      check("out_row",   32'(bus.out_row),   v ? 32'(pix_cnt / IMG_W) : 32'd0);
      check("out_last",  32'(bus.out_last),  32'(v && (pix_cnt == NPIX - 1)));
   endtask

   // One clock cycle: drive, check at negedge, advance model, return at posedge+1
   task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
      logic acc;
      logic xfer;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      @(negedge clk);
      check_outputs();
      if (!rst) begin
         acc  = iv && (q.size() <= 1);
         xfer = (q.size() > 0) && ordy;
         if (xfer) begin
            pix_cnt++;
            if (pix_cnt == NPIX) begin
               void'(q.pop_front());
               pix_cnt = 0;
            end
         end
         if (acc) begin
            q.push_back(d);
            n_acc++;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] v, input bit rnd_ready);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         done = (q.size() <= 1);
         step(1'b1, v, rnd_ready ? 1'($urandom % 2) : 1'b1);
      end
      check("send_accepted", 32'(done), 32'd1);
   endtask

   task automatic drain(input bit rnd_ready);
      for (int i = 0; i < 3000 && q.size() > 0; i++)
         step(1'b0, 8'($urandom), rnd_ready ? 1'($urandom % 2) : 1'b1);
      check("drain_empty", 32'(q.size()), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      pix_cnt  = 0;
      n_acc    = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'd0;
      bus.out_ready = 1'b0;
      #3;
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b0, 8'd0, 1'b1);

      // Single frame, continuous ready
      send(8'h5A, 1'b0);
      drain(1'b0);
      step(1'b0, 8'd0, 1'b1);

      // Back-to-back values, second held until taken
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      drain(1'b0);

      // Random stalls over three frames with random values
      n_acc = 0;
      for (int i = 0; i < 5000 && (n_acc < 3 || q.size() > 0); i++)
         step((n_acc < 3) && ($urandom % 8 == 0), 8'($urandom), 1'($urandom % 2));
      check("stall_frames", 32'(n_acc), 32'd3);
      drain(1'b1);

      // Value arriving exactly on the last transfer with nothing pending
      send(8'h44, 1'b0);
      for (int i = 0; i < 400 && !(q.size() == 1 && pix_cnt == NPIX - 1); i++)
         step(1'b0, 8'd0, 1'b1);
      step(1'b1, 8'h33, 1'b1);
      check("sim_data",  32'(bus.out_data),  32'h33);
      check("sim_col",   32'(bus.out_col),   32'd0);
      check("sim_row",   32'(bus.out_row),   32'd0);
      check("sim_valid", 32'(bus.out_valid), 32'd1);
      drain(1'b0);

      // Boundary values pass through untouched
      send(8'h00, 1'b0);
      send(8'hFF, 1'b0);
      drain(1'b1);

      // Reset mid-frame with a pending value held
      send(8'hA5, 1'b0);
      send(8'h3C, 1'b0);
      for (int i = 0; i < 400 && pix_cnt != 100; i++)
         step(1'b0, 8'd0, 1'b1);
      check("rst_pending", 32'(q.size()), 32'd2);
      rst = 1'b1;
      #1;
      q.delete();
      pix_cnt = 0;
      check_outputs();
      step(1'b0, 8'd0, 1'b1);
      rst = 1'b0;
      for (int i = 0; i < 6; i++)
         step(1'b0, 8'd0, 1'b1);
      send(8'h77, 1'b0);
      drain(1'b0);
      step(1'b0, 8'd0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
